// File: rtl/mips_core_pkg.sv
// mips_core: shared definitions for the AXI memory responder slice.
//   - ADDR_WIDTH / DATA_WIDTH bus width macros (guarded so any file may
//     also provide them)
//   - AXI ID and burst-length field widths
//   - responder FSM state encoding
`timescale 1ns/1ps
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mips_core;
  localparam int AXI_ID_W  = 4;
  localparam int AXI_LEN_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR_RESP = 3'd2,
    RD_WAIT = 3'd3,
    RD_DATA = 3'd4
  } resp_state_e;
endpackage

// File: rtl/responder_mem.sv
// responder_mem: single-port word memory behind the AXI responder.
// Ports:
//   clk    - clock
//   en     - access enable (read or write this cycle)
//   we     - 1 = write wdata to addr, 0 = read addr into rdata
//   addr   - word index
//   wdata  - whole-word write data (no byte strobes)
//   rdata  - registered read data, one-cycle latency; holds its value on
//            cycles without a read so a stalled consumer sees stable data
`timescale 1ns/1ps
module responder_mem #(
  parameter int INDEX_W = 12,
  parameter int WORD_W  = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [INDEX_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] words [0:(1<<INDEX_W)-1];

  // Read/write port -> registered read data (stage p1)
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) words[addr] <= wdata;
      else    rdata       <= words[addr];
    end
  end

endmodule

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI-style slave that serves INCR bursts from an
// internal word memory. One transaction (read or write) at a time.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   AW* (VALID/READY/ID/LEN/ADDR) - write address channel
//   W*  (VALID/READY/LAST/ID/DATA) - write data channel (WID ignored)
//   B*  (VALID/READY/ID)   - write response channel
//   AR* (VALID/READY/ID/LEN/ADDR) - read address channel
//   R*  (VALID/READY/LAST/ID/DATA) - read data channel
//   protocol_error         - sticky: WLAST disagreed with the beat count
// Addresses are word addresses; bursts wrap at the top of the array.
`timescale 1ns/1ps
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module axi_mem_responder
  import mips_core::*;
#(
  parameter int MEM_INDEX_WIDTH = 12,
  parameter int READ_DELAY      = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [AXI_ID_W-1:0]    AWID,
  input  logic [AXI_LEN_W-1:0]   AWLEN,
  input  logic [`ADDR_WIDTH-1:0] AWADDR,
  input  logic                   WVALID,
  output logic                   WREADY,
  input  logic                   WLAST,
  input  logic [AXI_ID_W-1:0]    WID,
  input  logic [`DATA_WIDTH-1:0] WDATA,
  output logic                   BVALID,
  input  logic                   BREADY,
  output logic [AXI_ID_W-1:0]    BID,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  input  logic [AXI_ID_W-1:0]    ARID,
  input  logic [AXI_LEN_W-1:0]   ARLEN,
  input  logic [`ADDR_WIDTH-1:0] ARADDR,
  output logic                   RVALID,
  input  logic                   RREADY,
  output logic                   RLAST,
  output logic [AXI_ID_W-1:0]    RID,
  output logic [`DATA_WIDTH-1:0] RDATA,
  output logic                   protocol_error
);

  localparam int DLY_W = (READ_DELAY > 1) ? $clog2(READ_DELAY + 1) : 1;

  resp_state_e                state_q, state_d;
  logic [AXI_ID_W-1:0]        bid_q, rid_q;
  logic [AXI_LEN_W-1:0]       beat_q, len_q;
  logic [MEM_INDEX_WIDTH-1:0] base_q;
  logic [DLY_W-1:0]           dly_q;
  logic                       perr_q;

  logic                       aw_hs, ar_hs, w_hs, r_hs, last_beat;
  logic                       mem_en, mem_we;
  logic [MEM_INDEX_WIDTH-1:0] mem_addr;
  logic [`DATA_WIDTH-1:0]     mem_rdata_p1;

  logic unused_inputs;
  assign unused_inputs = ^{WID, AWADDR[`ADDR_WIDTH-1:MEM_INDEX_WIDTH],
                           ARADDR[`ADDR_WIDTH-1:MEM_INDEX_WIDTH]};

  assign last_beat = (beat_q == len_q);

  always_comb begin
    state_d  = state_q;
    AWREADY  = 1'b0;
    ARREADY  = 1'b0;
    WREADY   = 1'b0;
    aw_hs    = 1'b0;
    ar_hs    = 1'b0;
    w_hs     = 1'b0;
    r_hs     = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = base_q + MEM_INDEX_WIDTH'(beat_q);
    case (state_q)
      IDLE: begin
        // rst_n gate keeps READY low while reset is held with VALID high.
        if (rst_n) begin
          if (AWVALID) begin
            AWREADY = 1'b1;
            aw_hs   = 1'b1;
            state_d = WR_DATA;
          end else if (ARVALID) begin
            ARREADY = 1'b1;
            ar_hs   = 1'b1;
            // Fetch beat 0 now so it is registered before RVALID rises,
            // even with no read delay.
            mem_en   = 1'b1;
            mem_addr = ARADDR[MEM_INDEX_WIDTH-1:0];
            state_d  = (READ_DELAY == 0) ? RD_DATA : RD_WAIT;
          end
        end
      end
      WR_DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          w_hs   = 1'b1;
          mem_en = 1'b1;
          mem_we = 1'b1;
          // Burst length comes from AWLEN alone; WLAST is only checked.
          if (last_beat) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (BREADY) state_d = IDLE;
      end
      RD_WAIT: begin
        if (dly_q == DLY_W'(1)) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (RREADY) begin
          r_hs = 1'b1;
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            // Prefetch the next word on the accepting edge: no bubble.
            mem_en   = 1'b1;
            mem_addr = base_q + MEM_INDEX_WIDTH'(beat_q) + MEM_INDEX_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bid_q   <= '0;
      rid_q   <= '0;
      beat_q  <= '0;
      dly_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (aw_hs) begin
        bid_q  <= AWID;
        beat_q <= '0;
      end
      if (ar_hs) begin
        rid_q  <= ARID;
        beat_q <= '0;
        dly_q  <= DLY_W'(READ_DELAY);
      end
      if (w_hs) begin
        beat_q <= beat_q + 4'd1;
        if (WLAST != last_beat) perr_q <= 1'b1;
      end
      if (r_hs) beat_q <= beat_q + 4'd1;
      if (state_q == RD_WAIT) dly_q <= dly_q - DLY_W'(1);
    end
  end

  // Burst base/length: plain data registers, qualified by state.
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      base_q <= AWADDR[MEM_INDEX_WIDTH-1:0];
      len_q  <= AWLEN;
    end else if (ar_hs) begin
      base_q <= ARADDR[MEM_INDEX_WIDTH-1:0];
      len_q  <= ARLEN;
    end
  end

  responder_mem #(
    .INDEX_W (MEM_INDEX_WIDTH),
    .WORD_W  (`DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (WDATA),
    .rdata (mem_rdata_p1)
  );

  // Registered memory word -> R channel; zeroed outside RD_DATA so reset
  // clears RDATA immediately.
  assign BVALID         = (state_q == WR_RESP);
  assign BID            = bid_q;
  assign RVALID         = (state_q == RD_DATA);
  assign RLAST          = RVALID && last_beat;
  assign RID            = rid_q;
  assign RDATA          = RVALID ? mem_rdata_p1 : '0;
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
`timescale 1ns/1ps
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_axi_mem_responder;
  logic clk = 1'b0;
  logic rst_n;
  logic AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic ARVALID, ARREADY, RVALID, RREADY, RLAST, protocol_error;
  logic [3:0] AWID, AWLEN, WID, BID, ARID, ARLEN, RID;
  logic [`ADDR_WIDTH-1:0] AWADDR, ARADDR;
  logic [`DATA_WIDTH-1:0] WDATA, RDATA;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_a [4];
  logic [31:0] wr_data [16];
  logic        wr_last [16];
  logic [31:0] rd_data [16];
  logic        rd_last [16];
  logic [3:0]  rd_id;
  int          rd_got;

  always #5 clk = ~clk;

  axi_mem_responder #(.MEM_INDEX_WIDTH(12), .READ_DELAY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWLEN(AWLEN), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WID(WID), .WDATA(WDATA),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
    .protocol_error(protocol_error)
  );

  // ---------------- stimulus helpers (all start/end at posedge+1) ----------------
  task automatic aw_xfer(input logic [3:0] id, input logic [`ADDR_WIDTH-1:0] addr,
                         input logic [3:0] len);
    int n = 0;
    AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
    @(negedge clk);
    while (!AWREADY && n < 50) begin @(negedge clk); n++; end
    if (!AWREADY) begin
      n_checks++; n_fail++;
      $display("FAIL aw_handshake_timeout: AWREADY=%0b required 1", AWREADY);
    end
    @(posedge clk); #1;
    AWVALID = 1'b0;
  endtask

  task automatic ar_xfer(input logic [3:0] id, input logic [`ADDR_WIDTH-1:0] addr,
                         input logic [3:0] len);
    int n = 0;
    ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
    @(negedge clk);
    while (!ARREADY && n < 50) begin @(negedge clk); n++; end
    if (!ARREADY) begin
      n_checks++; n_fail++;
      $display("FAIL ar_handshake_timeout: ARREADY=%0b required 1", ARREADY);
    end
    @(posedge clk); #1;
    ARVALID = 1'b0;
  endtask

  task automatic w_burst(input int n);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      WVALID = 1'b1; WDATA = wr_data[i]; WLAST = wr_last[i]; WID = 4'hF;
      @(negedge clk);
      while (!WREADY && k < 50) begin @(negedge clk); k++; end
      if (!WREADY) begin
        n_checks++; n_fail++;
        $display("FAIL w_handshake_timeout: beat %0d WREADY=%0b required 1", i, WREADY);
      end
      @(posedge clk); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic b_accept();
    int n = 0;
    BREADY = 1'b1;
    @(negedge clk);
    while (!BVALID && n < 50) begin @(negedge clk); n++; end
    if (!BVALID) begin
      n_checks++; n_fail++;
      $display("FAIL b_handshake_timeout: BVALID=%0b required 1", BVALID);
    end
    @(posedge clk); #1;
    BREADY = 1'b0;
  endtask

  task automatic read_burst(input int n);
    int cyc = 0;
    rd_got = 0; RREADY = 1'b1;
    while (rd_got < n && cyc < 100) begin
      @(negedge clk);
      if (RVALID) begin
        rd_data[rd_got] = RDATA; rd_last[rd_got] = RLAST; rd_id = RID; rd_got++;
      end
      @(posedge clk); #1; cyc++;
    end
    RREADY = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    AWVALID = 1'b1; ARVALID = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, protocol_error, BID, RID, RDATA} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: AWR=%0b WR=%0b BV=%0b ARR=%0b RV=%0b RL=%0b PE=%0b BID=%0h RID=%0h RDATA=%0h required all 0",
               AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, protocol_error, BID, RID, RDATA);
    end
    AWVALID = 1'b0; ARVALID = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    AWVALID = 1'b1; #1;
    n_checks++;
    if (AWREADY !== 1'b1) begin
      n_fail++; $display("FAIL reset_idle_awready: got %0b required 1", AWREADY);
    end
    AWVALID = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_burst();
    aw_xfer(4'd3, 'h10, 4'd3);
    for (int i = 0; i < 4; i++) begin wr_data[i] = exp_a[i]; wr_last[i] = (i == 3); end
    w_burst(4);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({BVALID, BID, protocol_error, WREADY} !== {1'b1, 4'd3, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL write_bresp_c%0d: BVALID=%0b BID=%0d PE=%0b WREADY=%0b required 1,3,0,0",
                 c, BVALID, BID, protocol_error, WREADY);
      end
      if (c < 2) begin @(posedge clk); #1; end
    end
    BREADY = 1'b1;
    @(posedge clk); #1;
    BREADY = 1'b0;
    @(negedge clk);
    n_checks++;
    if (BVALID !== 1'b0) begin
      n_fail++; $display("FAIL write_bvalid_drop: got %0b required 0", BVALID);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_read_burst();
    ar_xfer(4'd5, 'h10, 4'd3);
    RREADY = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (RVALID !== 1'b0) begin
        n_fail++; $display("FAIL read_latency_c%0d: RVALID=%0b required 0", c, RVALID);
      end
      @(posedge clk); #1;
    end
    for (int b = 0; b < 4; b++) begin
      if (b == 3) begin ARVALID = 1'b1; ARID = 4'd6; ARADDR = 'h12; ARLEN = 4'd0; end
      @(negedge clk);
      n_checks++;
      if ({RVALID, RID, RDATA, RLAST} !== {1'b1, 4'd5, exp_a[b], (b == 3)}) begin
        n_fail++;
        $display("FAIL read_beat%0d: RVALID=%0b RID=%0d RDATA=%h RLAST=%0b required 1,5,%h,%0b",
                 b, RVALID, RID, RDATA, RLAST, exp_a[b], (b == 3));
      end
      if (b == 3) begin
        n_checks++;
        if (ARREADY !== 1'b0) begin
          n_fail++; $display("FAIL read_last_arready: got %0b required 0", ARREADY);
        end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if ({RVALID, ARREADY} !== 2'b01) begin
      n_fail++; $display("FAIL read_after_last: RVALID=%0b ARREADY=%0b required 0,1", RVALID, ARREADY);
    end
    @(posedge clk); #1;
    ARVALID = 1'b0;
    read_burst(1);
    n_checks++;
    if (rd_got !== 1 || rd_data[0] !== exp_a[2] || rd_id !== 4'd6 || rd_last[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL read_back_to_back: got n=%0d data=%h id=%0d last=%0b required 1,%h,6,1",
               rd_got, rd_data[0], rd_id, rd_last[0], exp_a[2]);
    end
  endtask

  task automatic test_read_stall();
    int beat = 0;
    int cyc  = 0;
    ar_xfer(4'd5, 'h10, 4'd3);
    while (beat < 4 && cyc < 60) begin
      RREADY = (cyc % 3 == 0);
      @(negedge clk);
      if (RVALID) begin
        n_checks++;
        if ({RDATA, RLAST, RID} !== {exp_a[beat], (beat == 3), 4'd5}) begin
          n_fail++;
          $display("FAIL stall_cyc%0d: RDATA=%h RLAST=%0b RID=%0d required %h,%0b,5",
                   cyc, RDATA, RLAST, RID, exp_a[beat], (beat == 3));
        end
        if (RREADY) beat++;
      end
      @(posedge clk); #1; cyc++;
    end
    RREADY = 1'b0;
    @(negedge clk);
    n_checks++;
    if (beat !== 4 || RVALID !== 1'b0) begin
      n_fail++; $display("FAIL stall_complete: beats=%0d RVALID=%0b required 4,0", beat, RVALID);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_priority();
    AWVALID = 1'b1; AWID = 4'd7; AWADDR = 'h20; AWLEN = 4'd0;
    ARVALID = 1'b1; ARID = 4'd9; ARADDR = 'h20; ARLEN = 4'd0;
    @(negedge clk);
    n_checks++;
    if ({AWREADY, ARREADY} !== 2'b10) begin
      n_fail++; $display("FAIL prio_ready: AWREADY=%0b ARREADY=%0b required 1,0", AWREADY, ARREADY);
    end
    @(posedge clk); #1;
    AWVALID = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({WREADY, ARREADY} !== 2'b10) begin
      n_fail++; $display("FAIL prio_wr_data: WREADY=%0b ARREADY=%0b required 1,0", WREADY, ARREADY);
    end
    @(posedge clk); #1;
    wr_data[0] = 32'h0000_1234; wr_last[0] = 1'b1;
    w_burst(1);
    @(negedge clk);
    n_checks++;
    if ({BVALID, BID, ARREADY} !== {1'b1, 4'd7, 1'b0}) begin
      n_fail++; $display("FAIL prio_bresp: BVALID=%0b BID=%0d ARREADY=%0b required 1,7,0", BVALID, BID, ARREADY);
    end
    BREADY = 1'b1;
    @(posedge clk); #1;
    BREADY = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ARREADY !== 1'b1) begin
      n_fail++; $display("FAIL prio_read_accept: ARREADY=%0b required 1", ARREADY);
    end
    @(posedge clk); #1;
    ARVALID = 1'b0;
    read_burst(1);
    n_checks++;
    if (rd_got !== 1 || rd_data[0] !== 32'h0000_1234 || rd_id !== 4'd9) begin
      n_fail++;
      $display("FAIL prio_readback: n=%0d data=%h id=%0d required 1,00001234,9", rd_got, rd_data[0], rd_id);
    end
  endtask

  task automatic test_wrap_wlast();
    aw_xfer(4'd1, 'hFFF, 4'd1);
    wr_data[0] = 32'hDEAD_0001; wr_last[0] = 1'b1;
    wr_data[1] = 32'hDEAD_0002; wr_last[1] = 1'b0;
    w_burst(2);
    @(negedge clk);
    n_checks++;
    if ({BVALID, BID, protocol_error} !== {1'b1, 4'd1, 1'b1}) begin
      n_fail++; $display("FAIL wrap_bresp: BVALID=%0b BID=%0d PE=%0b required 1,1,1", BVALID, BID, protocol_error);
    end
    @(posedge clk); #1;
    b_accept();
    ar_xfer(4'd2, 'hFFF, 4'd1);
    read_burst(2);
    n_checks++;
    if (rd_got !== 2 || rd_data[0] !== 32'hDEAD_0001 || rd_data[1] !== 32'hDEAD_0002 ||
        rd_last[0] !== 1'b0 || rd_last[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_readback: n=%0d d0=%h d1=%h l0=%0b l1=%0b required 2,dead0001,dead0002,0,1",
               rd_got, rd_data[0], rd_data[1], rd_last[0], rd_last[1]);
    end
    ar_xfer(4'd2, 'h000, 4'd0);
    read_burst(1);
    n_checks++;
    if (rd_got !== 1 || rd_data[0] !== 32'hDEAD_0002) begin
      n_fail++; $display("FAIL wrap_word0: n=%0d data=%h required 1,dead0002", rd_got, rd_data[0]);
    end
    n_checks++;
    if (protocol_error !== 1'b1) begin
      n_fail++; $display("FAIL wrap_sticky: protocol_error=%0b required 1", protocol_error);
    end
  endtask

  task automatic test_reset_mid_read();
    int n = 0;
    ar_xfer(4'd4, 'h10, 4'd3);
    RREADY = 1'b1;
    @(negedge clk);
    while (!RVALID && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({RVALID, RDATA} !== {1'b1, exp_a[1]}) begin
      n_fail++; $display("FAIL midreset_beat2: RVALID=%0b RDATA=%h required 1,%h", RVALID, RDATA, exp_a[1]);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, protocol_error, BID, RID, RDATA} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: RV=%0b RL=%0b PE=%0b BID=%0h RID=%0h RDATA=%h required all 0",
               RVALID, RLAST, protocol_error, BID, RID, RDATA);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (RVALID !== 1'b0) begin
        n_fail++; $display("FAIL midreset_no_resume_c%0d: RVALID=%0b required 0", c, RVALID);
      end
      @(posedge clk); #1;
    end
    RREADY = 1'b0;
    ar_xfer(4'd4, 'h10, 4'd3);
    read_burst(4);
    n_checks++;
    if (rd_got !== 4 || rd_id !== 4'd4) begin
      n_fail++; $display("FAIL midreset_reread_count: n=%0d id=%0d required 4,4", rd_got, rd_id);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rd_data[i] !== exp_a[i] || rd_last[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL midreset_reread%0d: data=%h last=%0b required %h,%0b",
                 i, rd_data[i], rd_last[i], exp_a[i], (i == 3));
      end
    end
  endtask

  initial begin
    exp_a = '{32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3};
    rst_n = 1'b0;
    AWVALID = 1'b0; AWID = '0; AWLEN = '0; AWADDR = '0;
    WVALID = 1'b0; WLAST = 1'b0; WID = '0; WDATA = '0;
    BREADY = 1'b0;
    ARVALID = 1'b0; ARID = '0; ARLEN = '0; ARADDR = '0;
    RREADY = 1'b0;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_read_stall();
    test_write_priority();
    test_wrap_wlast();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
